// File: rtl/pwm_pulse_gen_pkg.sv
// Shared types and constants for the PWM pulse-train generator.
package pwm_pulse_gen_pkg;

    localparam int unsigned RamWidthDefault = 32;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StInactive,
        StDone
    } state_e;

endpackage

// File: rtl/pwm_phase_cnt.sv
// Loadable down-counter timing one PWM phase; expire flags the last cycle of the phase.
module pwm_phase_cnt
    import pwm_pulse_gen_pkg::*;
#(
    parameter int unsigned Width = RamWidthDefault
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [Width-1:0] value,
    input  logic             enable,
    output logic             expire
);

    localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

    logic [Width-1:0] cnt_q, cnt_d;

    // Counts down to 1 and holds there; never wraps through zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (enable && (cnt_q > One)) begin
            cnt_d = cnt_q - One;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q <= One);

endmodule

// File: rtl/pwm_pulse_gen.sv
// PWM pulse-train generator with finite or continuous trains and a registered output.
// Optional pulse-count status output enabled by defining PWM_PULSE_GEN_STATUS_EN.
module pwm_pulse_gen
    import pwm_pulse_gen_pkg::*;
#(
    parameter int unsigned _RAM_WIDTH = RamWidthDefault
) (
    input  logic                  io_clk,
    input  logic                  io_rst,
    input  logic                  io_start,
    input  logic                  io_stop,
    input  logic                  io_defaultLevel,
    input  logic [_RAM_WIDTH-1:0] io_highCnt,
    input  logic [_RAM_WIDTH-1:0] io_lowCnt,
    input  logic [_RAM_WIDTH-1:0] io_pulseNum,
    output logic                  io_pwm_out,
    output logic                  io_busy,
`ifdef PWM_PULSE_GEN_STATUS_EN
    output logic [_RAM_WIDTH-1:0] io_pulseCnt,
`endif
    output logic                  io_done
);

    localparam logic [_RAM_WIDTH-1:0] One = {{(_RAM_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic                  default_q, default_d;
    logic [_RAM_WIDTH-1:0] high_q, high_d;
    logic [_RAM_WIDTH-1:0] low_q, low_d;
    logic [_RAM_WIDTH-1:0] num_q, num_d;
    logic [_RAM_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
    logic                  out_q, out_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  cnt_load;
    logic [_RAM_WIDTH-1:0] cnt_value;
    logic                  cnt_en;
    logic                  cnt_expire;

    logic                  start_ok;
    logic [_RAM_WIDTH-1:0] low_eff;
    logic [_RAM_WIDTH-1:0] pulse_inc;

    // Stop wins over a simultaneous start; a zero-width active phase is never started.
    assign start_ok  = io_start && !io_stop && (io_highCnt != '0);
    assign low_eff   = (low_q == '0) ? One : low_q;
    assign pulse_inc = (pulse_cnt_q == '1) ? pulse_cnt_q : pulse_cnt_q + One;

    pwm_phase_cnt #(
        .Width (_RAM_WIDTH)
    ) u_phase_cnt (
        .clk    (io_clk),
        .rst_n  (io_rst),
        .load   (cnt_load),
        .value  (cnt_value),
        .enable (cnt_en),
        .expire (cnt_expire)
    );

    always_ff @(posedge io_clk or negedge io_rst) begin
        if (!io_rst) begin
            state_q     <= StIdle;
            default_q   <= 1'b0;
            high_q      <= '0;
            low_q       <= '0;
            num_q       <= '0;
            pulse_cnt_q <= '0;
            out_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            default_q   <= default_d;
            high_q      <= high_d;
            low_q       <= low_d;
            num_q       <= num_d;
            pulse_cnt_q <= pulse_cnt_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        default_d   = default_q;
        high_d      = high_q;
        low_d       = low_q;
        num_d       = num_q;
        pulse_cnt_d = pulse_cnt_q;
        cnt_load    = 1'b0;
        cnt_value   = high_q;
        cnt_en      = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d     = StActive;
                    default_d   = io_defaultLevel;
                    high_d      = io_highCnt;
                    low_d       = io_lowCnt;
                    num_d       = io_pulseNum;
                    pulse_cnt_d = '0;
                    cnt_load    = 1'b1;
                    cnt_value   = io_highCnt;
                end
            end
            StActive: begin
                if (io_stop) begin
                    state_d = StIdle;
                end else if (cnt_expire) begin
                    state_d   = StInactive;
                    cnt_load  = 1'b1;
                    cnt_value = low_eff;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            StInactive: begin
                if (io_stop) begin
                    state_d = StIdle;
                end else if (cnt_expire) begin
                    pulse_cnt_d = pulse_inc;
                    if ((num_q == '0) || (pulse_inc < num_q)) begin
                        state_d   = StActive;
                        cnt_load  = 1'b1;
                        cnt_value = high_q;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the current state, so the waveform lags the state by one edge.
    always_comb begin
        out_d  = default_q;
        busy_d = 1'b1;
        done_d = 1'b0;
        case (state_q)
            StIdle: begin
                out_d  = io_defaultLevel;
                busy_d = 1'b0;
            end
            StActive:   out_d = ~default_q;
            StInactive: out_d = default_q;
            StDone:     done_d = 1'b1;
            default: begin
                out_d  = io_defaultLevel;
                busy_d = 1'b0;
            end
        endcase
        if (io_stop && (state_q != StIdle)) begin
            out_d  = default_q;
            busy_d = 1'b0;
            done_d = 1'b0;
        end
    end

    assign io_pwm_out = out_q;
    assign io_busy    = busy_q;
    assign io_done    = done_q;

`ifdef PWM_PULSE_GEN_STATUS_EN
    assign io_pulseCnt = pulse_cnt_q;
`endif

endmodule

// File: tb/tb_pwm_pulse_gen.sv
// Self-checking bench for pwm_pulse_gen: expected {out, busy, done} per cycle queued, then compared.
module tb_pwm_pulse_gen;

    localparam int unsigned W = 32;

    logic         io_clk = 1'b0;
    logic         io_rst = 1'b0;
    logic         io_start = 1'b0;
    logic         io_stop = 1'b0;
    logic         io_defaultLevel = 1'b0;
    logic [W-1:0] io_highCnt = '0;
    logic [W-1:0] io_lowCnt = '0;
    logic [W-1:0] io_pulseNum = '0;
    logic         io_pwm_out;
    logic         io_busy;
    logic         io_done;
`ifdef PWM_PULSE_GEN_STATUS_EN
    logic [W-1:0] io_pulseCnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    always #5 io_clk = ~io_clk;

    pwm_pulse_gen #(
        ._RAM_WIDTH (W)
    ) dut (
        .io_clk          (io_clk),
        .io_rst          (io_rst),
        .io_start        (io_start),
        .io_stop         (io_stop),
        .io_defaultLevel (io_defaultLevel),
        .io_highCnt      (io_highCnt),
        .io_lowCnt       (io_lowCnt),
        .io_pulseNum     (io_pulseNum),
        .io_pwm_out      (io_pwm_out),
        .io_busy         (io_busy),
`ifdef PWM_PULSE_GEN_STATUS_EN
        .io_pulseCnt     (io_pulseCnt),
`endif
        .io_done         (io_done)
    );

    // Expected waveform of a train, one entry per edge after the start edge.
    task automatic push_train(input logic dl, input int high, input int low, input int num,
                              input int limit);
        int n = 0;
        int p = 0;
        bit fin = 0;
        int low_eff = (low == 0) ? 1 : low;
        while (!fin && n < limit) begin
            for (int i = 0; i < high && n < limit; i++) begin
                exp_q.push_back({~dl, 1'b1, 1'b0});
                n++;
            end
            for (int i = 0; i < low_eff && n < limit; i++) begin
                exp_q.push_back({dl, 1'b1, 1'b0});
                n++;
            end
            p++;
            if (num != 0 && p == num) begin
                if (n < limit) begin
                    exp_q.push_back({dl, 1'b1, 1'b1});
                    n++;
                end
                fin = 1;
            end
        end
    endtask

    task automatic push_idle(input logic dl, input int n);
        repeat (n) exp_q.push_back({dl, 2'b00});
    endtask

    task automatic sample(output logic [2:0] e, output logic [2:0] g, output bit empty);
        @(posedge io_clk);
        #1;
        g = {io_pwm_out, io_busy, io_done};
        empty = (exp_q.size() == 0);
        e = empty ? 3'bxxx : exp_q.pop_front();
    endtask

    task automatic set_cfg(input logic dl, input int h, input int l, input int n);
        io_defaultLevel = dl;
        io_highCnt = h;
        io_lowCnt = l;
        io_pulseNum = n;
        repeat (2) @(posedge io_clk);
        #1;
    endtask

    task automatic fire_start();
        @(negedge io_clk);
        io_start = 1'b1;
        @(posedge io_clk);
        #1;
        io_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] g;
        io_defaultLevel = 1'b1;
        repeat (3) @(posedge io_clk);
        #1;
        g = {io_pwm_out, io_busy, io_done};
        checks++;
        if (g !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold got %b exp 000", g);
        end
        @(negedge io_clk);
        io_rst = 1'b1;
        @(posedge io_clk);
        #1;
        g = {io_pwm_out, io_busy, io_done};
        checks++;
        if (g !== 3'b100) begin
            errors++;
            $display("FAIL reset_release_idle got %b exp 100", g);
        end
        io_defaultLevel = 1'b0;
        @(posedge io_clk);
        #1;
        g = {io_pwm_out, io_busy, io_done};
        checks++;
        if (g !== 3'b000) begin
            errors++;
            $display("FAIL idle_follow got %b exp 000", g);
        end
    endtask

    task automatic test_basic_train();
        logic [2:0] e, g;
        bit em;
        set_cfg(1'b0, 3, 2, 2);
        push_train(1'b0, 3, 2, 2, 1000);
        push_idle(1'b0, 3);
        fire_start();
        for (int i = 0; i < 14; i++) begin
            sample(e, g, em);
            checks++;
            if (em || g !== e) begin
                errors++;
                $display("FAIL basic_train edge N+%0d got %b exp %b", i + 1, g, e);
            end
        end
    endtask

    task automatic test_inverted_train();
        logic [2:0] e, g;
        bit em;
        set_cfg(1'b1, 1, 0, 3);
        push_train(1'b1, 1, 0, 3, 1000);
        push_idle(1'b1, 3);
        fire_start();
        for (int i = 0; i < 10; i++) begin
            sample(e, g, em);
            checks++;
            if (em || g !== e) begin
                errors++;
                $display("FAIL inverted_train edge N+%0d got %b exp %b", i + 1, g, e);
            end
        end
    endtask

    task automatic test_continuous_stop();
        logic [2:0] e, g;
        bit em;
        set_cfg(1'b0, 4, 4, 0);
        push_train(1'b0, 4, 4, 0, 19);
        push_idle(1'b0, 9);
        fire_start();
        for (int i = 0; i < 28; i++) begin
            if (i == 19) io_stop = 1'b1;
            sample(e, g, em);
            if (i == 19) io_stop = 1'b0;
            checks++;
            if (em || g !== e) begin
                errors++;
                $display("FAIL continuous_stop edge N+%0d got %b exp %b", i + 1, g, e);
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [2:0] e, g;
        bit em;
        set_cfg(1'b0, 0, 3, 2);
        push_idle(1'b0, 5);
        fire_start();
        for (int i = 0; i < 5; i++) begin
            sample(e, g, em);
            checks++;
            if (em || g !== e) begin
                errors++;
                $display("FAIL zero_high_start edge %0d got %b exp %b", i + 1, g, e);
            end
        end
        set_cfg(1'b1, 3, 3, 2);
        push_idle(1'b1, 5);
        @(negedge io_clk);
        io_start = 1'b1;
        io_stop = 1'b1;
        @(posedge io_clk);
        #1;
        io_start = 1'b0;
        io_stop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample(e, g, em);
            checks++;
            if (em || g !== e) begin
                errors++;
                $display("FAIL start_stop_same edge %0d got %b exp %b", i + 1, g, e);
            end
        end
    endtask

    task automatic test_reset_mid_train();
        logic [2:0] e, g;
        bit em;
        set_cfg(1'b1, 3, 2, 2);
        push_train(1'b1, 3, 2, 2, 4);
        fire_start();
        for (int i = 0; i < 4; i++) begin
            sample(e, g, em);
            checks++;
            if (em || g !== e) begin
                errors++;
                $display("FAIL pre_reset edge N+%0d got %b exp %b", i + 1, g, e);
            end
        end
        @(negedge io_clk);
        io_rst = 1'b0;
        #1;
        g = {io_pwm_out, io_busy, io_done};
        checks++;
        if (g !== 3'b000) begin
            errors++;
            $display("FAIL async_reset got %b exp 000", g);
        end
        @(negedge io_clk);
        io_rst = 1'b1;
        push_idle(1'b1, 10);
        for (int i = 0; i < 10; i++) begin
            sample(e, g, em);
            checks++;
            if (em || g !== e) begin
                errors++;
                $display("FAIL no_resume edge %0d got %b exp %b", i + 1, g, e);
            end
        end
    endtask

    task automatic test_config_change_busy();
        logic [2:0] e, g;
        bit em;
        set_cfg(1'b0, 3, 2, 2);
        push_train(1'b0, 3, 2, 2, 1000);
        push_idle(1'b0, 3);
        fire_start();
        for (int i = 0; i < 14; i++) begin
            if (i == 2) begin
                io_highCnt = 1;
                io_lowCnt = 7;
                io_pulseNum = 1;
                io_start = 1'b1;
            end
            sample(e, g, em);
            if (i == 2) io_start = 1'b0;
            checks++;
            if (em || g !== e) begin
                errors++;
                $display("FAIL config_change edge N+%0d got %b exp %b", i + 1, g, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_train();
        test_inverted_train();
        test_continuous_stop();
        test_ignored_start();
        test_reset_mid_train();
        test_config_change_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
